// File: rtl/riscv_lsu_pkg.sv
// rtl/riscv_lsu_pkg.sv - funct3 codes and FSM encoding shared by the load/store unit
package riscv_lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } lsu_state_e;

endpackage

// File: rtl/riscv_load_align.sv
// rtl/riscv_load_align.sv - extract and sign/zero-extend a load result from a memory word
// Ports: word_i (memory word), offset_i (byte offset), funct3_i (load type), data_o (result)
module riscv_load_align
    import riscv_lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word_i[{offset_i, 3'b000} +: 8];
    assign half_sel = word_i[{offset_i[1], 4'b0000} +: 16];

    always_comb begin
        data_o = 32'h0;
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LW:   data_o = word_i;
            F3_LBU:  data_o = {24'h0, byte_sel};
            F3_LHU:  data_o = {16'h0, half_sel};
            default: data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/riscv_load_store_unit.sv
// rtl/riscv_load_store_unit.sv - MEM-stage load/store unit with read-modify-write sub-word stores
// Optional range check: define LSU_RANGE_CHECK_EN.
// Ports: clk/rst; req_* request in, req_ready out; load_valid/load_data result;
//        err_misaligned/err_access error pulses; dAddress/dWriteData/dReadData/MemRead/MemWrite memory.
module riscv_load_store_unit
    import riscv_lsu_pkg::*;
#(
    parameter logic [31:0] DATA_START = 32'h0000_2000,
    parameter int          DATA_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        err_misaligned,
    output logic        err_access,
    output logic [31:0] dAddress,
    output logic [31:0] dWriteData,
    input  logic [31:0] dReadData,
    output logic        MemRead,
    output logic        MemWrite
);

    localparam logic [31:0] DATA_LAST = DATA_START + 32'(DATA_WORDS * 4) - 32'd1;

    lsu_state_e  state_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic [31:0] wdata_q;
    logic [29:0] addr_q;
    logic        load_valid_q;
    logic        err_mis_q;
    logic        err_acc_q;

    logic        bad;
    logic        in_range;
    logic        range_bad;
    logic        accept;
    logic        issue;
    logic        is_sw;
    logic        merging;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;
    logic [31:0] merged;
    logic [31:0] aligned;

    // Misalignment and illegal funct3 share one error path.
    always_comb begin
        bad = 1'b1;
        if (req_write) begin
            case (req_funct3)
                F3_SB:   bad = 1'b0;
                F3_SH:   bad = req_addr[0];
                F3_SW:   bad = |req_addr[1:0];
                default: bad = 1'b1;
            endcase
        end else begin
            case (req_funct3)
                F3_LB, F3_LBU: bad = 1'b0;
                F3_LH, F3_LHU: bad = req_addr[0];
                F3_LW:         bad = |req_addr[1:0];
                default:       bad = 1'b1;
            endcase
        end
    end

    assign in_range = (req_addr >= DATA_START) && (req_addr <= DATA_LAST);

`ifdef LSU_RANGE_CHECK_EN
    assign range_bad = ~in_range;
`else
    logic unused_range;
    assign unused_range = in_range;
    assign range_bad    = 1'b0;
`endif

    assign merging = (state_q == MERGE);
    assign accept  = req_valid & ~merging;
    assign issue   = accept & ~bad & ~range_bad;
    assign is_sw   = req_write & (req_funct3 == F3_SW);

    // Strobes are combinational from the request so memory acts on the accept edge;
    // the MERGE write strobe follows state_q and drops with an asynchronous reset.
    assign MemRead  = issue & ~is_sw;
    assign MemWrite = (issue & is_sw) | merging;

    always_comb begin
        lane_mask = 32'h0;
        lane_data = 32'h0;
        if (f3_q == F3_SB) begin
            lane_mask = 32'h0000_00FF << {off_q, 3'b000};
            lane_data = (wdata_q & 32'h0000_00FF) << {off_q, 3'b000};
        end else begin
            lane_mask = 32'h0000_FFFF << {off_q[1], 4'b0000};
            lane_data = (wdata_q & 32'h0000_FFFF) << {off_q[1], 4'b0000};
        end
    end

    assign merged = (dReadData & ~lane_mask) | lane_data;

    assign dAddress   = merging ? {addr_q, 2'b00} :
                        issue   ? {req_addr[31:2], 2'b00} : 32'h0;
    assign dWriteData = merging           ? merged    :
                        (issue & is_sw)   ? req_wdata : 32'h0;

    riscv_load_align u_align (
        .word_i   (dReadData),
        .offset_i (off_q),
        .funct3_i (f3_q),
        .data_o   (aligned)
    );

    assign req_ready      = ~merging;
    assign load_valid     = load_valid_q;
    assign load_data      = load_valid_q ? aligned : 32'h0;
    assign err_misaligned = err_mis_q;
    assign err_access     = err_acc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            off_q        <= 2'b00;
            f3_q         <= 3'b000;
            wdata_q      <= 32'h0;
            addr_q       <= 30'h0;
            load_valid_q <= 1'b0;
            err_mis_q    <= 1'b0;
            err_acc_q    <= 1'b0;
        end else begin
            load_valid_q <= issue & ~req_write;
            err_mis_q    <= accept & bad;
            err_acc_q    <= accept & ~bad & range_bad;
            if (accept) begin
                off_q   <= req_addr[1:0];
                f3_q    <= req_funct3;
                wdata_q <= req_wdata;
                addr_q  <= req_addr[31:2];
            end
            case (state_q)
                IDLE:    if (issue & req_write & ~is_sw) state_q <= MERGE;
                MERGE:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_load_store_unit.sv
// tb/tb_riscv_load_store_unit.sv - directed self-checking bench for riscv_load_store_unit
module tb_riscv_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        load_valid;
    logic [31:0] load_data;
    logic        err_misaligned;
    logic        err_access;
    logic [31:0] dAddress;
    logic [31:0] dWriteData;
    logic [31:0] dReadData;
    logic        MemRead;
    logic        MemWrite;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:63];

    always #5 clk = ~clk;

    riscv_load_store_unit dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .load_valid     (load_valid),
        .load_data      (load_data),
        .err_misaligned (err_misaligned),
        .err_access     (err_access),
        .dAddress       (dAddress),
        .dWriteData     (dWriteData),
        .dReadData      (dReadData),
        .MemRead        (MemRead),
        .MemWrite       (MemWrite)
    );

    // Word-wide synchronous-read memory, no byte enables.
    always @(posedge clk) begin
        if (MemRead)  dReadData <= mem[dAddress[7:2]];
        if (MemWrite) mem[dAddress[7:2]] <= dWriteData;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        req_valid  = v;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
        chk({tag, "_outs"}, {27'h0, load_valid, err_misaligned, err_access, MemRead, MemWrite}, 32'h0);
        chk({tag, "_ldata"}, load_data, 32'h0);
        chk({tag, "_daddr"}, dAddress, 32'h0);
        chk({tag, "_dwdata"}, dWriteData, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[1]    = 32'h8899AABB;
        dReadData = 32'h0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // LB 0x2005
        drive(1'b1, 1'b0, 3'd0, 32'h2005, 32'h0);
        #1;
        chk("lb_memread", {31'h0, MemRead}, 32'h1);
        chk("lb_memwrite", {31'h0, MemWrite}, 32'h0);
        chk("lb_daddr", dAddress, 32'h2004);
        @(negedge clk);
        step_lbu_begin: begin end
        // LBU 0x2005 issued back-to-back, LB result checked now
        chk("lb_valid", {31'h0, load_valid}, 32'h1);
        chk("lb_data", load_data, 32'hFFFFFFAA);
        drive(1'b1, 1'b0, 3'd4, 32'h2005, 32'h0);
        step();
        chk("lbu_data", load_data, 32'h000000AA);

        // LH / LHU / LW back-to-back
        drive(1'b1, 1'b0, 3'd1, 32'h2006, 32'h0);
        step();
        chk("lh_valid", {31'h0, load_valid}, 32'h1);
        chk("lh_data", load_data, 32'hFFFF8899);
        drive(1'b1, 1'b0, 3'd5, 32'h2006, 32'h0);
        step();
        chk("lhu_valid", {31'h0, load_valid}, 32'h1);
        chk("lhu_data", load_data, 32'h00008899);
        drive(1'b1, 1'b0, 3'd2, 32'h2004, 32'h0);
        step();
        chk("lw_valid", {31'h0, load_valid}, 32'h1);
        chk("lw_data", load_data, 32'h8899AABB);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        step();
        chk("idle_valid", {31'h0, load_valid}, 32'h0);

        // SB 0x2005 wdata 0x12 -> read-modify-write
        drive(1'b1, 1'b1, 3'd0, 32'h2005, 32'h12);
        #1;
        chk("sb_memread", {31'h0, MemRead}, 32'h1);
        chk("sb_memwrite0", {31'h0, MemWrite}, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        #1;
        chk("sb_merge_ready", {31'h0, req_ready}, 32'h0);
        chk("sb_merge_strobes", {30'h0, MemRead, MemWrite}, 32'h1);
        chk("sb_merge_daddr", dAddress, 32'h2004);
        chk("sb_merge_wdata", dWriteData, 32'h889912BB);
        step();
        chk("sb_ready_back", {31'h0, req_ready}, 32'h1);
        chk("sb_no_loadvalid", {31'h0, load_valid}, 32'h0);
        drive(1'b1, 1'b0, 3'd2, 32'h2004, 32'h0);
        step();
        chk("sb_readback", load_data, 32'h889912BB);

        // SW 0x2008 then readback
        drive(1'b1, 1'b1, 3'd2, 32'h2008, 32'hDEADBEEF);
        #1;
        chk("sw_strobes", {30'h0, MemRead, MemWrite}, 32'h1);
        chk("sw_daddr", dAddress, 32'h2008);
        chk("sw_wdata", dWriteData, 32'hDEADBEEF);
        step();
        chk("sw_ready", {31'h0, req_ready}, 32'h1);
        chk("sw_no_loadvalid", {31'h0, load_valid}, 32'h0);
        drive(1'b1, 1'b0, 3'd2, 32'h2008, 32'h0);
        step();
        chk("sw_readback", load_data, 32'hDEADBEEF);

        // Misaligned / illegal
        drive(1'b1, 1'b0, 3'd2, 32'h2006, 32'h0);
        #1;
        chk("lw_mis_strobes", {30'h0, MemRead, MemWrite}, 32'h0);
        @(negedge clk);
        chk("lw_mis_err", {31'h0, err_misaligned}, 32'h1);
        chk("lw_mis_valid", {31'h0, load_valid}, 32'h0);
        drive(1'b1, 1'b1, 3'd1, 32'h2003, 32'h5566);
        #1;
        chk("sh_mis_strobes", {30'h0, MemRead, MemWrite}, 32'h0);
        @(negedge clk);
        chk("sh_mis_err", {31'h0, err_misaligned}, 32'h1);
        chk("sh_mis_ready", {31'h0, req_ready}, 32'h1);
        drive(1'b1, 1'b0, 3'd3, 32'h2004, 32'h0);
        #1;
        chk("f3_ill_strobes", {30'h0, MemRead, MemWrite}, 32'h0);
        @(negedge clk);
        chk("f3_ill_err", {31'h0, err_misaligned}, 32'h1);
        chk("f3_ill_valid", {31'h0, load_valid}, 32'h0);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        step();
        chk("err_pulse_end", {31'h0, err_misaligned}, 32'h0);

        // SH 0x2004 with reset during MERGE
        mem[1] = 32'h8899AABB;
        drive(1'b1, 1'b1, 3'd1, 32'h2004, 32'h5566);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        #1;
        chk("sh_merge_memwrite", {31'h0, MemWrite}, 32'h1);
        chk("sh_merge_wdata", dWriteData, 32'h88995566);
        rst = 1'b1;
        #1;
        chk("rst_drop_memwrite", {31'h0, MemWrite}, 32'h0);
        chk("rst_drop_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mem_intact", mem[1], 32'h8899AABB);
        chk_all_zero("after_rst");
        @(negedge clk);
        drive(1'b1, 1'b0, 3'd2, 32'h2004, 32'h0);
        step();
        chk("rst_readback", load_data, 32'h8899AABB);

`ifdef LSU_RANGE_CHECK_EN
        drive(1'b1, 1'b0, 3'd2, 32'h1FFC, 32'h0);
        #1;
        chk("rng_low_strobes", {30'h0, MemRead, MemWrite}, 32'h0);
        @(negedge clk);
        chk("rng_low_err", {30'h0, err_access, err_misaligned}, 32'h2);
        chk("rng_low_valid", {31'h0, load_valid}, 32'h0);
        drive(1'b1, 1'b0, 3'd2, 32'h2100, 32'h0);
        #1;
        chk("rng_high_strobes", {30'h0, MemRead, MemWrite}, 32'h0);
        @(negedge clk);
        chk("rng_high_err", {31'h0, err_access}, 32'h1);
        drive(1'b1, 1'b0, 3'd2, 32'h1FFE, 32'h0);
        @(negedge clk);
        chk("rng_mis_priority", {30'h0, err_access, err_misaligned}, 32'h1);
        drive(1'b1, 1'b0, 3'd2, 32'h20FC, 32'h0);
        #1;
        chk("rng_last_memread", {31'h0, MemRead}, 32'h1);
        @(negedge clk);
        chk("rng_last_err", {31'h0, err_access}, 32'h0);
        chk("rng_last_valid", {31'h0, load_valid}, 32'h1);
`else
        drive(1'b1, 1'b0, 3'd2, 32'h2100, 32'h0);
        #1;
        chk("norng_memread", {31'h0, MemRead}, 32'h1);
        @(negedge clk);
        chk("norng_err", {31'h0, err_access}, 32'h0);
        chk("norng_valid", {31'h0, load_valid}, 32'h1);
`endif
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
